// File: rtl/sha256_w_expander_param_if.sv
// rtl/sha256_w_expander_param_if.sv - load/stream handshake bundle for the SHA-256 W expander
interface sha256_w_expander_param_if #(
  parameter int WPC = 1
);
  logic               start;
  logic [511:0]       block_in;
  logic               busy;
  logic [32*WPC-1:0]  w_out;
  logic               w_valid;
  logic               w_ready;
  logic [5:0]         round_idx;
  logic               done;

  modport master (
    output start, block_in, w_ready,
    input  busy, w_out, w_valid, round_idx, done
  );

  modport slave (
    input  start, block_in, w_ready,
    output busy, w_out, w_valid, round_idx, done
  );
endinterface

// File: rtl/sha256_w_expander_param.sv
// rtl/sha256_w_expander_param.sv - SHA-256 message schedule expander, WPC words per beat
// Optional SHA256_W_KADD_EN: emit W[t]+K[t] instead of raw W[t].
module sha256_w_expander_param #(
  parameter int WPC        = 1,
  parameter int LAST_ROUND = 63
) (
  input logic                      CLK,
  input logic                      RST,
  sha256_w_expander_param_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [5:0] LAST_T = 6'(LAST_ROUND - WPC + 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q;
  logic        fire;
  logic        last_beat;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign fire      = (state_q == S_RUN) && bus.w_ready;
  assign last_beat = (t_q == LAST_T);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (fire && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Window holds W[t..t+15]; a consume shifts by WPC and appends the words
  // that follow, each later word in the same beat chaining on earlier ones.
  always_comb begin : ext_blk
    logic [31:0] ext [16+WPC];
    for (int i = 0; i < 16; i++) ext[i] = win_q[i];
    for (int j = 0; j < WPC; j++) begin
      if (int'(t_q) + 16 + j <= LAST_ROUND)
        ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
      else
        ext[16+j] = '0;
    end
    for (int i = 0; i < 16; i++) win_d[i] = ext[i+WPC];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      t_q <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      t_q <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= bus.block_in[511-32*i -: 32];
    end else if (fire) begin
      t_q <= last_beat ? 6'd0 : t_q + 6'(WPC);
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.w_valid   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.round_idx = t_q;

`ifdef SHA256_W_KADD_EN
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  for (genvar j = 0; j < WPC; j++) begin : g_out
    assign bus.w_out[32*(WPC-j)-1 -: 32] = win_q[j] + K_TAB[t_q + 6'(j)];
  end
`else
  for (genvar j = 0; j < WPC; j++) begin : g_out
    assign bus.w_out[32*(WPC-j)-1 -: 32] = win_q[j];
  end
`endif

endmodule
